// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares a single cache controller between two requesters: port 0 (instruction
// fetch) and port 1 (load/store unit). Contested requests are resolved
// round-robin against the last port that was served. Each transaction walks
// IDLE -> ISSUE -> WAIT -> RESP. WAIT holds the cache command until c_done or
// until a watchdog expires after TIMEOUT cycles. Saturating hit/miss counters
// record every transaction the cache completes.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0      port 0 request (held until ack0), write flag,
//                              address, write data
//   ack0/rdata0/err0           port 0 one-cycle completion pulse, read data and
//                              timeout flag (both held until the next ack0)
//   req1 .. err1               same set for port 1
//   c_read/c_write             command strobes to the cache, held through WAIT
//   c_addr/c_wdata             cache address / write data (0 when idle)
//   c_rdata/c_done/c_hit       cache read data, completion pulse, hit flag
//   busy                       high whenever a transaction is in flight
//   hit_cnt/miss_cnt           saturating completed-hit / completed-miss counts
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,

    output logic              c_read,
    output logic              c_write,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] c_rdata,
    input  logic              c_done,
    input  logic              c_hit,

    output logic              busy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    // Wide enough to hold TIMEOUT itself, so the incremented timer never wraps
    // before the watchdog comparison fires.
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               gnt_q,   gnt_d;    // port id of the transaction in flight
    logic               last_q,  last_d;   // port id served most recently
    logic [TMR_W-1:0]   tmr_q,   tmr_d;

    // Transaction snapshot taken at grant time; never reset because nothing
    // observes it outside ISSUE/WAIT.
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    // Response registers and statistics.
    logic [DATA_W-1:0]  rdata0_q, rdata1_q;
    logic               err0_q,   err1_q;
    logic [CNT_W-1:0]   hit_q,    miss_q;

    // Decode strobes from the next-state logic.
    logic               grant_en;
    logic               done_ok;
    logic               tmo;
    logic [TMR_W-1:0]   tmr_inc;
    logic [DATA_W-1:0]  resp_data;
    logic               cmd_active;

    assign tmr_inc = tmr_q + TMR_W'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        tmr_d    = tmr_q;
        grant_en = 1'b0;
        done_ok  = 1'b0;
        tmo      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_en = 1'b1;
                    state_d  = S_ISSUE;
                    // Contest goes to the port that was not served last;
                    // otherwise the lone requester wins.
                    if (req0 && req1) begin
                        gnt_d = ~last_q;
                    end else begin
                        gnt_d = req1;
                    end
                end
            end

            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                tmr_d = tmr_inc;
                // c_done takes priority over a watchdog expiring in the
                // same cycle.
                if (c_done) begin
                    done_ok = 1'b1;
                    state_d = S_RESP;
                end else if (tmr_inc == TMR_W'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Writes return zero data; an aborted transaction also returns zero.
    assign resp_data = (done_ok && !we_q) ? c_rdata : '0;

    // -------------------------------------------------------------------------
    // Control state, responses and counters (asynchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;   // port 0 wins the first contest
            tmr_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;

            // Response registers load on the WAIT->RESP edge, so the new
            // value appears exactly in the ack cycle and then holds.
            if (done_ok || tmo) begin
                if (gnt_q) begin
                    rdata1_q <= resp_data;
                    err1_q   <= tmo;
                end else begin
                    rdata0_q <= resp_data;
                    err0_q   <= tmo;
                end
            end

            if (done_ok) begin
                if (c_hit) begin
                    hit_q <= sat_inc(hit_q);
                end else begin
                    miss_q <= sat_inc(miss_q);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Request snapshot; later changes on the requester side are ignored
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (grant_en) begin
            we_q    <= gnt_d ? we1    : we0;
            addr_q  <= gnt_d ? addr1  : addr0;
            wdata_q <= gnt_d ? wdata1 : wdata0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Commands are decoded straight from the state register so that an
    // asynchronous reset drops them in the same cycle.
    assign cmd_active = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign c_read   = cmd_active && !we_q;
    assign c_write  = cmd_active &&  we_q;
    assign c_addr   = cmd_active ? addr_q  : '0;
    assign c_wdata  = cmd_active ? wdata_q : '0;

    assign ack0     = (state_q == S_RESP) && !gnt_q;
    assign ack1     = (state_q == S_RESP) &&  gnt_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;

    assign busy     = (state_q != S_IDLE);
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares one cache_controller between two requesters, port 0 (instruction fetch) and port 1 (load/store unit). Uses fair round-robin arbitration. Each transaction is sequenced through a 4-state FSM with a done-handshake toward the cache and a timeout watchdog. Saturating hit/miss statistics counters are provided for performance measurement.

Parameters:
ADDR_W, 9, address width passed to the cache
DATA_W, 64, data width
TIMEOUT, 255, max cycles waiting for c_done before aborting (>=1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
reset  in  1  reset
req0  in  1  port 0 request, held until ack0
we0  in  1  port 0 write(1)/read(0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 one-cycle completion pulse
rdata0  out  DATA_W  port 0 read data, valid with ack0
err0  out  1  port 0 timeout flag, valid with ack0
req1/we1/addr1/wdata1/ack1/rdata1/err1  same as port 0, for port 1
c_read  out  1  read command to cache
c_write  out  1  write command to cache
c_addr  out  ADDR_W  cache address
c_wdata  out  DATA_W  cache write data
c_rdata  in  DATA_W  cache read data, valid with c_done
c_done  in  1  cache completion pulse
c_hit  in  1  hit indication, sampled with c_done
busy  out  1  high whenever state != IDLE
hit_cnt  out  CNT_W  completed hits
miss_cnt  out  CNT_W  completed misses (c_done with c_hit=0)

Behaviour:
- reset: asynchronous, active-high; clock clk.
- Reset values: state=IDLE, all outputs 0, counters 0, last_grant=1 (port 0 wins first contest).
- FSM states:
  - IDLE
    - If no req, stay.
    - If exactly one req, grant it.
    - If both req, grant the port != last_grant.
    - On grant: latch we/addr/wdata into internal regs, record grant id, go to ISSUE.
  - ISSUE: drive c_addr/c_wdata from latched regs; assert c_read (we=0) or c_write (we=1). Clear timer. Go to WAIT.
  - WAIT
    - Keep c_read/c_write and c_addr/c_wdata asserted/stable; timer++.
    - On c_done=1: capture c_rdata (forced to 0 for writes) and c_hit; increment hit_cnt or miss_cnt; go to RESP.
    - Else if timer==TIMEOUT: drop the command and set the err flag; no counter update; go to RESP.
  - RESP
    - Deassert c_read/c_write.
    - Pulse ack of the granted port for exactly 1 cycle, with rdata/err valid that cycle.
    - Set last_grant = granted id; go to IDLE.
- rdataX/errX hold their values until the next ackX.
- The non-granted port never sees ack and must keep its req asserted.
- Latency: grant to ack = 3 + N cycles, where N = WAIT cycles until c_done (N>=1). Minimum 4 cycles per transaction; back-to-back alternation between ports guaranteed.
- A requester must drop or renew req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Requester inputs are ignored after latching; changes during a transaction do not affect c_addr.
- c_done outside WAIT is ignored. c_done and timeout in the same cycle: c_done wins, no error.
- Counters saturate at all-ones; no wrap.
- Reset mid-transaction: c_read/c_write drop immediately, no ack is issued, the transaction is lost.

Test Plan:
- Single read port 0: req0=1, we0=0, addr0=9'h1C0; cache returns c_done after 2 WAIT cycles with c_rdata=64'hDEAD_BEEF, c_hit=1 -> ack0 at cycle 5 after grant, rdata0=64'hDEAD_BEEF, err0=0, hit_cnt=1.
- Simultaneous requests: req0=req1=1 right after reset -> port 0 granted first, then port 1; grants alternate 0,1,0,1 over 4 transactions while both are held.
- Write miss port 1: we1=1, wdata1=64'h1234, c_hit=0 -> c_write held high until c_done, c_wdata=64'h1234, ack1 with rdata1=0, miss_cnt=1.
- Timeout with TIMEOUT=4 and c_done never asserted -> ack0 after 4 WAIT cycles, err0=1, counters unchanged, busy returns to 0.
- Reset asserted during WAIT -> c_read=0 in the same cycle, state IDLE, no ack; next request completes normally.
- Saturation with CNT_W=2: 5 hits -> hit_cnt stays at 3.
